dma_line_tlp_planner: RTL
=========================

// Module: dma_line_tlp_planner
// PURPOSE
// Per-line DMA write planner between the video stream front-end and the TLP formatter of the DMA write path.
// Accepts one line descriptor per video line, tracks per-plane line base addresses (fstart, line pitch), and splits each plane's line into PCIe memory-write requests.
// Each request respects the negotiated max payload and never crosses a 4 KB boundary.
// Supports N planes (mono/packed or planar R/G/B); the downstream TLP builder consumes one request per handshake.
// PARAMETERS
// NUM_PLANES         3    number of independent planes/address contexts (1..4)
// MAX_PAYLOAD_BYTES  128  compile-time payload ceiling in bytes (128/256/512)
// SIZE_WIDTH         24   width of line size / line pitch registers (bytes)
// PORTS
// axi_clk          in   1                clock
// axi_reset        in   1                synchronous reset, active-high
// cfg_fstart       in   NUM_PLANES*64    per-plane frame start byte address; plane p = [64p+63:64p]
// cfg_line_size    in   SIZE_WIDTH       bytes per line per plane
// cfg_line_pitch   in   SIZE_WIDTH       byte distance between consecutive line bases
// cfg_setmaxpld    in   3                PCIe max payload code (000=128 B, 001=256 B, 010=512 B, ...)
// line_valid       in   1                line descriptor valid
// line_sof         in   1                descriptor is first line of a frame
// line_ready       out  1                planner can accept a descriptor
// req_valid        out  1                write request valid
// req_ready        in   1                downstream accepts request
// req_addr         out  64               request byte address (bits [1:0] always 0)
// req_len_dw       out  10               request length in DWORDs (1..MAX_PAYLOAD_BYTES/4)
// req_plane        out  2                plane index of the request
// req_last         out  1                last request of the line (all planes)
// line_done        out  1                one-cycle pulse, line fully issued
// err_nosof        out  1                one-cycle pulse, line dropped (no SOF seen since reset)
// BEHAVIOUR
// - Reset: all outputs 0 except line_ready=1; plane bases=0, sof_seen=0, FSM=IDLE. A reset mid-line aborts the line immediately; the pending request is dropped.
// - FSM states and transitions:
//   - IDLE: line_ready=1. A handshake snapshots cfg_line_size, cfg_line_pitch, and eff_pld = min(MAX_PAYLOAD_BYTES, 128<<cfg_setmaxpld). The snapshot holds for the whole line.
//   - Base update on handshake: SOF -> base[p]=cfg_fstart[p], sof_seen=1. Non-SOF with sof_seen -> base[p]+=pitch, modulo 2^64.
//   - Non-SOF with !sof_seen -> err_nosof pulse next cycle, stay IDLE.
//   - CALC (1 cycle): addr=base[0], rem=line_size, plane=0. Go to ISSUE, or to DONE if line_size==0.
//   - ISSUE: chunk = min(rem, eff_pld, 4096-addr[11:0]); req_len_dw=chunk>>2. On handshake: addr+=chunk, rem-=chunk.
//     When rem reaches 0, go to the next plane (addr=base[p+1], rem=line_size), or to DONE after plane NUM_PLANES-1.
//   - DONE (1 cycle): line_done=1. Return to IDLE; line_ready=1 in the same cycle.
// - Latency: descriptor handshake -> first req_valid = 2 cycles. Back-to-back requests have zero bubble, including plane changes: the next request is presented the cycle after a handshake.
// - Handshake: while req_valid&&!req_ready, all req_* signals hold stable. req_valid never drops without a handshake, except on reset.
// - req_last=1 only on the final request of plane NUM_PLANES-1.
// - Alignment: addresses and sizes are DWORD units; bits [1:0] of fstart, line_size, and pitch are ignored (treated as 0).
// - A descriptor presented while busy is not accepted (line_ready=0). cfg_* changes while busy take effect on the next line.
// CONFIGURATION
// - DMA_REVERSE_Y_EN defined: adds input reverse_y (1 bit), sampled at each non-SOF handshake. reverse_y=1 -> base[p]-=pitch (bottom-up frames); reverse_y=0 -> base[p]+=pitch.
// - DMA_REVERSE_Y_EN undefined: no reverse_y port; base[p] always increments by pitch.
// TESTING
// - NUM_PLANES=1, fstart=0xA0000000, size=0x1000, pitch=0x1000, maxpld=000, SOF line -> 32 requests at 0xA0000000+0x80*k, len 32; req_last on the 32nd. Next line's first addr = 0xA0001000.
// - 4 KB cross: fstart=0x10000FC0, size=0x100, eff_pld=128 -> exactly 3 requests: (0x10000FC0, 16), (0x10001000, 32), (0x10001080, 16).
// - NUM_PLANES=3, fstart 0x1000/0x2000/0x3000, size=0x40 -> requests at 0x1000, 0x2000, 0x3000 (len 16, plane 0/1/2), no gaps; req_last only on plane 2; line_done 1 cycle after.
// - req_ready low 5 cycles mid-line -> req_* constant throughout; total DW issued = line_size/4; no duplicates.
// - After reset, non-SOF descriptor -> err_nosof pulse, no req_valid. SOF with size=0 -> line_done 2 cycles after accept, no requests. Reset during ISSUE -> req_valid=0 next cycle.
// - DMA_REVERSE_Y_EN, reverse_y=1, fstart=0xA0100000, pitch=0x1000 -> line 2 base 0xA00FF000.

Source files
------------

// File: rtl/dma_line_tlp_planner.sv
// Per-line DMA write planner: splits each plane's video line into max-payload, 4 KB-safe PCIe write requests.
// Optional macro DMA_REVERSE_Y_EN adds i_reverse_y so that non-SOF lines can step line bases downward.
module dma_line_tlp_planner #(
  parameter int NUM_PLANES        = 3,
  parameter int MAX_PAYLOAD_BYTES = 128,
  parameter int SIZE_WIDTH        = 24
) (
  input  logic                     i_axi_clk,
  input  logic                     i_axi_reset,
  input  logic [NUM_PLANES*64-1:0] i_cfg_fstart,
  input  logic [SIZE_WIDTH-1:0]    i_cfg_line_size,
  input  logic [SIZE_WIDTH-1:0]    i_cfg_line_pitch,
  input  logic [2:0]               i_cfg_setmaxpld,
`ifdef DMA_REVERSE_Y_EN
  input  logic                     i_reverse_y,
`endif
  input  logic                     i_line_valid,
  input  logic                     i_line_sof,
  output logic                     o_line_ready,
  output logic                     o_req_valid,
  input  logic                     i_req_ready,
  output logic [63:0]              o_req_addr,
  output logic [9:0]               o_req_len_dw,
  output logic [1:0]               o_req_plane,
  output logic                     o_req_last,
  output logic                     o_line_done,
  output logic                     o_err_nosof
);

  localparam int PLD_W = 16;
  localparam int CW    = (SIZE_WIDTH > PLD_W) ? SIZE_WIDTH : PLD_W;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_ISSUE, S_DONE} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [SIZE_WIDTH-1:0] r_size;
  logic [SIZE_WIDTH-1:0] r_rem;
  logic [PLD_W-1:0]      r_eff_pld;
  logic [63:0]           r_base [NUM_PLANES];
  logic [63:0]           r_addr;
  logic [1:0]            r_plane;
  logic                  r_sof_seen;
  logic                  r_err_nosof;

  logic                  w_line_hs;
  logic                  w_accept;
  logic                  w_req_hs;
  logic [SIZE_WIDTH-1:0] w_size_in;
  logic [SIZE_WIDTH-1:0] w_pitch_in;
  logic [PLD_W-1:0]      w_pld_code;
  logic [PLD_W-1:0]      w_eff_pld_in;
  logic [CW-1:0]         w_rem_ext;
  logic [CW-1:0]         w_pld_ext;
  logic [CW-1:0]         w_bound;
  logic [CW-1:0]         w_chunk;
  logic                  w_last_chunk;
  logic                  w_last_plane;
  logic                  w_step_down;
  logic [63:0]           w_next_base;

  assign w_line_hs  = o_line_ready & i_line_valid;
  assign w_accept   = w_line_hs & (i_line_sof | r_sof_seen);
  assign w_req_hs   = o_req_valid & i_req_ready;
  assign w_size_in  = {i_cfg_line_size[SIZE_WIDTH-1:2], 2'b00};
  assign w_pitch_in = {i_cfg_line_pitch[SIZE_WIDTH-1:2], 2'b00};
  assign w_pld_code = PLD_W'(128) << i_cfg_setmaxpld;
  assign w_eff_pld_in = (w_pld_code > PLD_W'(MAX_PAYLOAD_BYTES)) ? PLD_W'(MAX_PAYLOAD_BYTES) : w_pld_code;

`ifdef DMA_REVERSE_Y_EN
  assign w_step_down = i_reverse_y;
`else
  assign w_step_down = 1'b0;
`endif

  // Chunk is the tightest of remaining bytes, payload ceiling and distance to the next 4 KB page.
  always_comb begin
    w_rem_ext = CW'(r_rem);
    w_pld_ext = CW'(r_eff_pld);
    w_bound   = CW'(13'h1000 - {1'b0, r_addr[11:0]});
    w_chunk   = w_rem_ext;
    if (w_pld_ext < w_chunk) w_chunk = w_pld_ext;
    if (w_bound < w_chunk)   w_chunk = w_bound;
  end

  assign w_last_chunk = (w_rem_ext == w_chunk);
  assign w_last_plane = (r_plane == 2'(NUM_PLANES - 1));

  always_comb begin
    w_next_base = '0;
    for (int p = 0; p < NUM_PLANES; p++) begin
      if (2'(p) == r_plane + 2'd1) w_next_base = r_base[p];
    end
  end

  always_ff @(posedge i_axi_clk) begin
    if (i_axi_reset) r_state <= S_IDLE;
    else             r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    o_line_ready = 1'b0;
    o_req_valid  = 1'b0;
    o_line_done  = 1'b0;
    o_req_last   = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_line_ready = 1'b1;
        w_state_nxt  = w_accept ? S_CALC : S_IDLE;
      end
      S_CALC: begin
        w_state_nxt = (r_size == '0) ? S_DONE : S_ISSUE;
      end
      S_ISSUE: begin
        o_req_valid = 1'b1;
        o_req_last  = w_last_plane & w_last_chunk;
        if (w_req_hs && w_last_chunk && w_last_plane) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        o_line_done  = 1'b1;
        o_line_ready = 1'b1;
        w_state_nxt  = w_accept ? S_CALC : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign o_req_addr   = r_addr;
  assign o_req_len_dw = 10'(w_chunk >> 2);
  assign o_req_plane  = r_plane;
  assign o_err_nosof  = r_err_nosof;

  // A plane change reloads addr/rem in the same edge as the final handshake, so issue never bubbles.
  always_ff @(posedge i_axi_clk) begin
    if (i_axi_reset) begin
      r_size      <= '0;
      r_rem       <= '0;
      r_eff_pld   <= '0;
      r_addr      <= '0;
      r_plane     <= '0;
      r_sof_seen  <= 1'b0;
      r_err_nosof <= 1'b0;
      for (int p = 0; p < NUM_PLANES; p++) r_base[p] <= '0;
    end else begin
      r_err_nosof <= w_line_hs & ~i_line_sof & ~r_sof_seen;
      if (w_accept) begin
        r_size    <= w_size_in;
        r_eff_pld <= w_eff_pld_in;
        if (i_line_sof) begin
          r_sof_seen <= 1'b1;
          for (int p = 0; p < NUM_PLANES; p++)
            r_base[p] <= {i_cfg_fstart[64*p+2 +: 62], 2'b00};
        end else begin
          for (int p = 0; p < NUM_PLANES; p++)
            r_base[p] <= w_step_down ? r_base[p] - 64'(w_pitch_in) : r_base[p] + 64'(w_pitch_in);
        end
      end
      case (r_state)
        S_CALC: begin
          r_addr  <= r_base[0];
          r_rem   <= r_size;
          r_plane <= '0;
        end
        S_ISSUE: begin
          if (w_req_hs) begin
            if (w_last_chunk && !w_last_plane) begin
              r_plane <= r_plane + 2'd1;
              r_addr  <= w_next_base;
              r_rem   <= r_size;
            end else begin
              r_addr <= r_addr + 64'(w_chunk);
              r_rem  <= r_rem - SIZE_WIDTH'(w_chunk);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
